// File: rtl/field_merge_unit_if.sv
// IV-bus port of the field merge unit.
// The unit drives address, strobes and write data; the bus returns read data.
interface field_merge_unit_if;
    logic [7:0] bus_addr;
    logic       bus_rd;
    logic [7:0] bus_rdata;
    logic       bus_wr;
    logic [7:0] bus_wdata;

    modport master (
        output bus_addr,
        output bus_rd,
        input  bus_rdata,
        output bus_wr,
        output bus_wdata
    );

    modport slave (
        input  bus_addr,
        input  bus_rd,
        output bus_rdata,
        input  bus_wr,
        input  bus_wdata
    );
endinterface

// File: rtl/field_merge_unit.sv
// Read-modify-write of an L-bit field into an IV-bus byte.
// The field is rotated into place, so it may wrap from bit 7 to bit 0.
module field_merge_unit (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_hazard,
    input  logic                      start,
    input  logic [7:0]                addr_in,
    input  logic [7:0]                data_in,
    input  logic [2:0]                L_select,
    input  logic [2:0]                pos,
    field_merge_unit_if.master        bus,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        WR
    } state_t;

    state_t     state;
    logic [7:0] addr_r;
    logic [7:0] data_r;
    logic [2:0] len_r;
    logic [2:0] pos_r;
    logic [7:0] wdata_r;
    logic [7:0] merged;

    function automatic logic [7:0] rotl(
        input logic [7:0] x,
        input logic [2:0] p
    );
        logic [15:0] t;
        t = {x, x} << p;
        return t[15:8];
    endfunction

    function automatic logic [7:0] fmask(input logic [2:0] l);
        if (l == 3'd0) return 8'hFF;
        return (8'd1 << l) - 8'd1;
    endfunction

    always_comb begin
        logic [7:0] fm;
        logic [7:0] pm;
        fm     = fmask(len_r);
        pm     = rotl(fm, pos_r);
        merged = (rotl(data_r & fm, pos_r) & pm)
               | (bus.bus_rdata & ~pm);
    end

    // Every transition and capture is frozen while the pipeline stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_r  <= 8'h00;
            data_r  <= 8'h00;
            len_r   <= 3'd0;
            pos_r   <= 3'd0;
            wdata_r <= 8'h00;
        end else if (!data_hazard) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_r <= addr_in;
                        data_r <= data_in;
                        len_r  <= L_select;
                        pos_r  <= pos;
                        if (L_select == 3'd0) begin
                            wdata_r <= rotl(data_in, pos);
                            state   <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD:  state <= CAP;
                CAP: begin
                    wdata_r <= merged;
                    state   <= WR;
                end
                WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_addr  = addr_r;
    assign bus.bus_wdata = wdata_r;
    assign bus.bus_rd    = (state == RD) && !data_hazard;
    assign bus.bus_wr    = (state == WR) && !data_hazard;
    assign done          = (state == WR) && !data_hazard;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_field_merge_unit.sv
// Directed bench for field_merge_unit: vector table plus
// stall, busy-rejection and mid-operation reset sequences.
module tb_field_merge_unit;

    logic       clk;
    logic       rst;
    logic       data_hazard;
    logic       start;
    logic [7:0] addr_in;
    logic [7:0] data_in;
    logic [2:0] L_select;
    logic [2:0] pos;
    logic       busy;
    logic       done;
    logic [7:0] mem_dest;

    int n_chk;
    int n_fail;

    field_merge_unit_if bus ();

    field_merge_unit dut (
        .clk        (clk),
        .rst        (rst),
        .data_hazard(data_hazard),
        .start      (start),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .L_select   (L_select),
        .pos        (pos),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave: read data appears after bus_rd and is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.bus_rdata <= 8'h00;
        else if (bus.bus_rd) bus.bus_rdata <= mem_dest;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [2:0] l;
        logic [2:0] p;
        logic [7:0] dest;
        logic [7:0] wd;
        int         lat;
    } vec_t;

    vec_t tbl[8];

    int         r_done_cyc;
    int         r_rd;
    int         r_wr;
    int         r_done;
    int         r_mis;
    logic [7:0] r_wd;
    logic [7:0] r_ad;

    // Start in cycle 0; per-cycle start and hazard masks for cycles 1..n.
    task automatic run(
        input logic [7:0]  a,
        input logic [7:0]  d,
        input logic [2:0]  l,
        input logic [2:0]  p,
        input logic [15:0] smask,
        input logic [15:0] hz,
        input int          ncyc
    );
        r_done_cyc = 0;
        r_rd = 0;
        r_wr = 0;
        r_done = 0;
        r_mis = 0;
        r_wd = 8'h00;
        r_ad = 8'h00;
        @(posedge clk); #1;
        start = 1'b1;
        addr_in = a;
        data_in = d;
        L_select = l;
        pos = p;
        data_hazard = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = smask[c];
            data_hazard = hz[c];
            @(negedge clk);
            if (bus.bus_rd) r_rd++;
            if (bus.bus_wr) r_wr++;
            if (done !== bus.bus_wr) r_mis++;
            if (done) begin
                r_done++;
                if (r_done_cyc == 0) begin
                    r_done_cyc = c;
                    r_wd = bus.bus_wdata;
                    r_ad = bus.bus_addr;
                end
            end
        end
        start = 1'b0;
        data_hazard = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        data_hazard = 1'b0;
        start = 1'b0;
        addr_in = 8'h00;
        data_in = 8'h00;
        L_select = 3'd0;
        pos = 3'd0;
        mem_dest = 8'h00;

        tbl[0] = '{8'h30, 8'h00, 3'd3, 3'd2, 8'hFF, 8'hE3, 3};
        tbl[1] = '{8'h31, 8'h0F, 3'd4, 3'd6, 8'h00, 8'hC3, 3};
        tbl[2] = '{8'h32, 8'hFF, 3'd1, 3'd0, 8'h00, 8'h01, 3};
        tbl[3] = '{8'h12, 8'hA5, 3'd0, 3'd0, 8'h77, 8'hA5, 1};
        tbl[4] = '{8'h13, 8'hA5, 3'd0, 3'd4, 8'h77, 8'h5A, 1};
        tbl[5] = '{8'h40, 8'h00, 3'd7, 3'd1, 8'hFF, 8'h01, 3};
        tbl[6] = '{8'h41, 8'h15, 3'd5, 3'd5, 8'h5A, 8'hBA, 3};
        tbl[7] = '{8'h42, 8'h02, 3'd2, 3'd7, 8'h7E, 8'h7F, 3};

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset bus_rd", int'(bus.bus_rd), 0);
        check("reset bus_wr", int'(bus.bus_wr), 0);
        check("reset bus_addr", int'(bus.bus_addr), 0);
        check("reset bus_wdata", int'(bus.bus_wdata), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mem_dest = tbl[i].dest;
            run(tbl[i].addr, tbl[i].data, tbl[i].l, tbl[i].p,
                16'h0, 16'h0, 6);
            check($sformatf("v%0d wdata", i), int'(r_wd), int'(tbl[i].wd));
            check($sformatf("v%0d addr", i), int'(r_ad), int'(tbl[i].addr));
            check($sformatf("v%0d latency", i), r_done_cyc, tbl[i].lat);
            check($sformatf("v%0d rd count", i), r_rd,
                  (tbl[i].l == 3'd0) ? 0 : 1);
            check($sformatf("v%0d wr count", i), r_wr, 1);
            check($sformatf("v%0d done count", i), r_done, 1);
            check($sformatf("v%0d done!=wr", i), r_mis, 0);
        end

        // Stall: hazard in cycles 1,2 (RD) and 5 (WR).
        mem_dest = 8'hFF;
        run(8'h55, 8'h00, 3'd3, 3'd2, 16'h0, 16'h0026, 10);
        check("stall latency", r_done_cyc, 6);
        check("stall rd count", r_rd, 1);
        check("stall wr count", r_wr, 1);
        check("stall done count", r_done, 1);
        check("stall wdata", int'(r_wd), 8'hE3);
        check("stall addr", int'(r_ad), 8'h55);

        // Start held high while busy: only one merge.
        mem_dest = 8'h00;
        run(8'h60, 8'h0F, 3'd4, 3'd6, 16'h000E, 16'h0, 8);
        check("busy-rej done count", r_done, 1);
        check("busy-rej rd count", r_rd, 1);
        check("busy-rej wdata", int'(r_wd), 8'hC3);

        // Back-to-back full bytes at the 2-cycle interval.
        run(8'h70, 8'h81, 3'd0, 3'd1, 16'h0004, 16'h0, 6);
        check("b2b full done count", r_done, 2);

        // Asynchronous reset while in CAP.
        mem_dest = 8'hFF;
        @(posedge clk); #1;
        start = 1'b1;
        addr_in = 8'h99;
        data_in = 8'h00;
        L_select = 3'd3;
        pos = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        check("cap busy before rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst busy", int'(busy), 0);
        check("rst bus_addr", int'(bus.bus_addr), 0);
        check("rst bus_wdata", int'(bus.bus_wdata), 0);
        check("rst bus_rd", int'(bus.bus_rd), 0);
        check("rst bus_wr", int'(bus.bus_wr), 0);
        check("rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        r_wr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.bus_wr || done || busy) r_wr++;
        end
        check("post-rst activity", r_wr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
